adc_spi_scanner: RTL and testbench

ADC_SPI_SCANNER -- requirements
Module: adc_spi_scanner

---
 rtl/adc_spi_scanner.sv | 236 +++++++++++++++++++++++
 tb/tb_adc_spi_scanner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_scanner.sv
// adc_spi_scanner: round-robin SPI front end for a multi-channel ADC.
// Each conversion sends the channel address, waits one settle bit, shifts in
// DATA_W result bits MSB first, then offers the result to a one-entry output
// buffer with handshake and sticky overrun reporting.
module adc_spi_scanner #(
    parameter int DATA_W  = 8,
    parameter int CH_W    = 2,
    parameter int GAP_CYC = 2
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2**CH_W-1:0]   ch_mask,
    input  logic                 adc_miso,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic                 adc_mosi,
    output logic [DATA_W-1:0]    sample_data,
    output logic [CH_W-1:0]      sample_ch,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 clr_ovr,
    output logic                 busy
);

    localparam int NCH = 2**CH_W;
    localparam logic [4:0] ADDR_LAST = 5'(CH_W - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
    localparam logic [4:0] GAP_LAST  = 5'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        ADDR     = 3'd2,
        SETTLE   = 3'd3,
        DATA     = 3'd4,
        DONE     = 3'd5,
        GAP      = 3'd6
    } state_t;

    // Lowest set mask bit strictly above prev (or from 0 inclusive on the
    // very first conversion), wrapping around to the lowest set bit.
    function automatic logic [CH_W-1:0] pick_channel(
        input logic [NCH-1:0]  mask,
        input logic [CH_W-1:0] prev,
        input logic            first
    );
        logic            found;
        logic [CH_W-1:0] res;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && mask[i] && (first || (i > int'(prev)))) begin
                res   = CH_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && mask[i]) begin
                res   = CH_W'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    state_t            state_r, state_nx;
    logic              phase_r, phase_nx;      // 0 = sclk low phase, 1 = high phase
    logic [4:0]        cnt_r, cnt_nx;          // bit index or gap cycle count
    logic [CH_W-1:0]   addr_r, addr_nx;        // address shifter, MSB drives mosi
    logic [DATA_W-1:0] shift_r, shift_nx;      // result shifter
    logic [CH_W-1:0]   ch_r, ch_nx;            // channel of current/previous conversion
    logic              first_r, first_nx;      // no conversion launched since reset
    logic              start_s;
    logic              conv_s, serial_s;
    logic              cs_n_nx, sclk_nx, mosi_nx, busy_nx;
    logic              load_s, drop_s;

    assign start_s = en && (ch_mask != '0);

    // Next-state and datapath sequencing for one conversion frame.
    always_comb begin
        state_nx = state_r;
        phase_nx = phase_r;
        cnt_nx   = cnt_r;
        addr_nx  = addr_r;
        shift_nx = shift_r;
        ch_nx    = ch_r;
        first_nx = first_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nx = CS_SETUP;
                    ch_nx    = pick_channel(ch_mask, ch_r, first_r);
                    first_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            CS_SETUP: begin
                state_nx = ADDR;
                phase_nx = 1'b0;
                cnt_nx   = 5'd0;
                addr_nx  = ch_r;
            end
            ADDR: begin
                if (!phase_r) begin
                    phase_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    addr_nx  = addr_r << 1;
                    if (cnt_r == ADDR_LAST) begin
                        state_nx = SETTLE;
                        cnt_nx   = 5'd0;
                    end else begin
                        cnt_nx = cnt_r + 5'd1;
                    end
                end
            end
            SETTLE: begin
                if (!phase_r) begin
                    phase_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    state_nx = DATA;
                    cnt_nx   = 5'd0;
                end
            end
            DATA: begin
                if (!phase_r) begin
                    phase_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    shift_nx = {shift_r[DATA_W-2:0], adc_miso};
                    if (cnt_r == DATA_LAST) begin
                        state_nx = DONE;
                        cnt_nx   = 5'd0;
                    end else begin
                        cnt_nx = cnt_r + 5'd1;
                    end
                end
            end
            DONE: begin
                state_nx = GAP;
                cnt_nx   = 5'd0;
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nx = 5'd0;
                    if (start_s) begin
                        state_nx = CS_SETUP;
                        ch_nx    = pick_channel(ch_mask, ch_r, first_r);
                        first_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt_r + 5'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = 1'b0;
                cnt_nx   = 5'd0;
            end
        endcase
    end

    // Pin values for the upcoming cycle, so the SPI pins come straight from flops.
    always_comb begin
        conv_s   = (state_nx == CS_SETUP) || (state_nx == ADDR) ||
                   (state_nx == SETTLE)   || (state_nx == DATA);
        serial_s = (state_nx == ADDR) || (state_nx == SETTLE) || (state_nx == DATA);
        cs_n_nx  = !conv_s;
        sclk_nx  = serial_s && phase_nx;
        mosi_nx  = (state_nx == ADDR) ? addr_nx[CH_W-1] : 1'b0;
        busy_nx  = conv_s || (state_nx == DONE);
    end

    assign load_s = (state_r == DONE) && (!sample_valid || sample_ready);
    assign drop_s = (state_r == DONE) && sample_valid && !sample_ready;

    // Sequencer state and registered SPI pins; reset aborts any conversion.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            phase_r  <= 1'b0;
            cnt_r    <= 5'd0;
            addr_r   <= '0;
            shift_r  <= '0;
            ch_r     <= '0;
            first_r  <= 1'b1;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            adc_mosi <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_nx;
            phase_r  <= phase_nx;
            cnt_r    <= cnt_nx;
            addr_r   <= addr_nx;
            shift_r  <= shift_nx;
            ch_r     <= ch_nx;
            first_r  <= first_nx;
            adc_cs_n <= cs_n_nx;
            adc_sclk <= sclk_nx;
            adc_mosi <= mosi_nx;
            busy     <= busy_nx;
        end
    end

    // One-entry output buffer with handshake and sticky overrun (set beats clear).
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_s) begin
                sample_data  <= shift_r;
                sample_ch    <= ch_r;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (drop_s) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Directed scoreboard bench for adc_spi_scanner at default parameters.
module tb_adc_spi_scanner;

    localparam int DATA_W  = 8;
    localparam int CH_W    = 2;
    localparam int GAP_CYC = 2;

    logic              clk_div = 1'b0;
    logic              rst;
    logic              en;
    logic [3:0]        ch_mask;
    logic              adc_miso = 1'b0;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic              adc_mosi;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              clr_ovr;
    logic              busy;

    adc_spi_scanner #(.DATA_W(DATA_W), .CH_W(CH_W), .GAP_CYC(GAP_CYC)) dut (
        .clk_div(clk_div), .rst(rst), .en(en), .ch_mask(ch_mask),
        .adc_miso(adc_miso), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_mosi(adc_mosi), .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
    );

    always #5 clk_div = ~clk_div;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                hs_cyc = 0;
    exp_t              exp_q[$];
    logic [DATA_W-1:0] word_q[$];
    logic [CH_W-1:0]   addr_q[$];
    logic [DATA_W-1:0] cur_word = '0;
    logic [CH_W-1:0]   addr_sh = '0;
    int                sclk_cnt = 0;

    always @(posedge clk_div) cyc <= cyc + 1;

    // ADC model: takes the next queued word per frame, records the address,
    // presents result bits MSB first during each sclk high phase of DATA.
    always @(negedge adc_cs_n or posedge adc_sclk) begin
        if (!adc_sclk) begin
            sclk_cnt = 0;
            addr_sh  = '0;
            adc_miso = 1'b0;
            if (word_q.size() > 0) cur_word = word_q.pop_front();
            else cur_word = '0;
        end else begin
            sclk_cnt++;
            if (sclk_cnt <= CH_W) begin
                addr_sh = {addr_sh[CH_W-2:0], adc_mosi};
                if (sclk_cnt == CH_W) addr_q.push_back(addr_sh);
            end else if (sclk_cnt >= CH_W + 2 && sclk_cnt < CH_W + 2 + DATA_W) begin
                adc_miso = cur_word[DATA_W - 1 - (sclk_cnt - CH_W - 2)];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(sample_data), 32'(e.data));
            chk({tag, "_ch"}, 32'(sample_ch), 32'(e.ch));
        end
    endtask

    task automatic wait_handshake(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_div);
            if (sample_valid && sample_ready) ok = 1'b1;
        end
        hs_cyc = cyc;
        chk({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) pop_check(tag);
    endtask

    task automatic wait_conv_end(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_div);
            if (busy) ok = 1'b1;
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 300 && !ok; i++) begin
                @(negedge clk_div);
                if (!busy) ok = 1'b1;
            end
        end
        chk({tag, "_end"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_until_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_div);
            if (busy && adc_cs_n) ok = 1'b1;
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_sclk_high(input string tag, input int min_cnt);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_div);
            if (!adc_cs_n && adc_sclk && sclk_cnt >= min_cnt) ok = 1'b1;
        end
        chk({tag, "_sclk"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int  t1;
        bit  bad;
        rst = 1'b1; en = 1'b0; ch_mask = 4'b0000; sample_ready = 1'b1; clr_ovr = 1'b0;

        // reset state
        #3;
        chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rst_sclk", 32'(adc_sclk), 32'd0);
        chk("rst_mosi", 32'(adc_mosi), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_div);
        rst = 1'b0;

        // empty mask: never starts
        en = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_div);
            if (adc_cs_n !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk("mask0_idle", 32'(bad), 32'd0);

        // mask 0101: ch0 then ch2, period check
        word_q.push_back(8'hA5); exp_q.push_back('{ch: 2'd0, data: 8'hA5});
        word_q.push_back(8'h5A); exp_q.push_back('{ch: 2'd2, data: 8'h5A});
        ch_mask = 4'b0101;
        wait_handshake("conv_a5");
        t1 = hs_cyc;
        wait_handshake("conv_ch2");
        en = 1'b0;
        chk("period", 32'(hs_cyc - t1), 32'd26);
        chk("addr_cnt", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() >= 2) begin
            chk("addr_ch0", 32'(addr_q[0]), 32'd0);
            chk("addr_ch2", 32'(addr_q[1]), 32'd2);
        end
        repeat (5) @(negedge clk_div);
        chk("idle_cs_n", 32'(adc_cs_n), 32'd1);

        // overrun: ready low over two conversions
        sample_ready = 1'b0;
        ch_mask = 4'b0001;
        word_q.push_back(8'h3C); exp_q.push_back('{ch: 2'd0, data: 8'h3C});
        word_q.push_back(8'hC3);
        en = 1'b1;
        wait_conv_end("ovr1");
        chk("ovr1_valid", 32'(sample_valid), 32'd1);
        pop_check("ovr1");
        chk("ovr1_flag", 32'(overrun), 32'd0);
        wait_conv_end("ovr2");
        en = 1'b0;
        chk("ovr2_flag", 32'(overrun), 32'd1);
        chk("ovr2_held", 32'(sample_data), 32'h3C);
        repeat (4) @(negedge clk_div);
        clr_ovr = 1'b1;
        @(negedge clk_div);
        clr_ovr = 1'b0;
        chk("clr_ovr", 32'(overrun), 32'd0);
        chk("clr_valid", 32'(sample_valid), 32'd1);

        // ready asserted in the DONE cycle with a full buffer
        word_q.push_back(8'h77); exp_q.push_back('{ch: 2'd0, data: 8'h77});
        en = 1'b1;
        wait_until_done("ld");
        sample_ready = 1'b1;
        @(negedge clk_div);
        sample_ready = 1'b0;
        en = 1'b0;
        chk("ld_valid", 32'(sample_valid), 32'd1);
        pop_check("ld");
        chk("ld_ovr", 32'(overrun), 32'd0);
        sample_ready = 1'b1;
        @(negedge clk_div);
        chk("consume_valid", 32'(sample_valid), 32'd0);

        // en dropped during ADDR
        ch_mask = 4'b0100;
        word_q.push_back(8'h96); exp_q.push_back('{ch: 2'd2, data: 8'h96});
        en = 1'b1;
        wait_sclk_high("endrop", 1);
        en = 1'b0;
        wait_handshake("endrop");
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_div);
            if (adc_cs_n !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk("endrop_idle", 32'(bad), 32'd0);

        // reset during DATA with a held result
        sample_ready = 1'b0;
        ch_mask = 4'b0011;
        word_q.push_back(8'h11); exp_q.push_back('{ch: 2'd0, data: 8'h11});
        word_q.push_back(8'hEE);
        en = 1'b1;
        wait_conv_end("prerst");
        pop_check("prerst");
        chk("prerst_valid", 32'(sample_valid), 32'd1);
        wait_sclk_high("rstdata", CH_W + 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("arst_sclk", 32'(adc_sclk), 32'd0);
        chk("arst_valid", 32'(sample_valid), 32'd0);
        chk("arst_data", 32'(sample_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk_div);
        word_q.delete();
        word_q.push_back(8'h42); exp_q.push_back('{ch: 2'd0, data: 8'h42});
        sample_ready = 1'b1;
        rst = 1'b0;
        wait_handshake("restart");
        en = 1'b0;
        repeat (5) @(negedge clk_div);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
